// File: rtl/sr04_pkg.sv
// Shared types and constants for the multi-sensor HC-SR04 scan scheduler.
package sr04_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StDiv,
    StResult,
    StGuard
  } state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'hFFFF;
  localparam logic [15:0] CM_DIVISOR  = 16'd58;

  function automatic int unsigned us_to_clks(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/sr04_us_div.sv
// Serial divide-by-58 (microseconds to centimetres) with a start/done handshake.
module sr04_us_div
  import sr04_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_us,
  output logic        o_done,
  output logic [15:0] o_cm
);

  logic [15:0] r_rem;
  logic [15:0] r_q;
  logic        r_run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_run  <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        r_rem <= i_us;
        r_q   <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        if (r_rem >= CM_DIVISOR) begin
          r_rem <= r_rem - CM_DIVISOR;
          r_q   <= r_q + 16'd1;
        end else begin
          r_run  <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_cm = r_q;

endmodule

// File: rtl/sr04_scan_sched.sv
// Round-robin HC-SR04 scheduler: trigger, time echo, publish, guard, next sensor.
// Define DIST_CM_EN to report centimetres through a serial divider instead of microseconds.
module sr04_scan_sched
  import sr04_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned N_SENS     = 4,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned RISE_TO_US = 5000,
  parameter int unsigned ECHO_TO_US = 38000,
  parameter int unsigned GUARD_US   = 60000,
  localparam int unsigned CW        = $clog2(N_SENS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [N_SENS-1:0] i_echo,
  output logic [N_SENS-1:0] o_trig,
  output logic [15:0]       o_dis,
  output logic [CW-1:0]     o_ch,
  output logic              o_dis_vld,
  output logic              o_timeout,
  output logic              o_busy
);

  localparam int unsigned     PRE        = us_to_clks(CLK_HZ, 1);
  localparam logic [15:0]     PRE_LAST   = 16'(PRE - 1);
  localparam logic [15:0]     PRE_MEAS   = (PRE > 1) ? 16'd1 : 16'd0;
  localparam logic [15:0]     TRIG_LAST  = 16'(TRIG_US - 1);
  localparam logic [15:0]     RISE_LAST  = 16'(RISE_TO_US - 1);
  localparam logic [15:0]     ECHO_LAST  = 16'(ECHO_TO_US - 1);
  localparam logic [15:0]     GUARD_LAST = 16'(GUARD_US - 1);
  localparam logic [CW-1:0]   PTR_LAST   = CW'(N_SENS - 1);
  localparam logic [N_SENS-1:0] ONE      = {{(N_SENS - 1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [CW-1:0]     r_ptr;
  logic [15:0]       r_pre;
  logic [15:0]       r_us;
  logic [15:0]       r_meas;
  logic [N_SENS-1:0] r_echo_s1;
  logic [N_SENS-1:0] r_echo_s2;
  logic [N_SENS-1:0] r_echo_s3;

  logic          w_us_tick;
  logic          w_echo_cur;
  logic          w_echo_prv;
  logic          w_rise;
  logic          w_fall;
  logic [CW-1:0] w_ptr_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_echo_s1 <= '0;
      r_echo_s2 <= '0;
      r_echo_s3 <= '0;
    end else begin
      r_echo_s1 <= i_echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_s3 <= r_echo_s2;
    end
  end

  assign w_echo_cur = r_echo_s2[r_ptr];
  assign w_echo_prv = r_echo_s3[r_ptr];
  assign w_rise     = w_echo_cur & ~w_echo_prv;
  assign w_fall     = ~w_echo_cur & w_echo_prv;
  assign w_us_tick  = (r_pre >= PRE_LAST);
  assign w_ptr_next = (r_ptr == PTR_LAST) ? '0 : r_ptr + CW'(1);
  assign o_busy     = (r_state != StIdle);

`ifdef DIST_CM_EN
  logic        r_div_start;
  logic        w_div_done;
  logic [15:0] w_div_cm;

  sr04_us_div u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (r_div_start),
    .i_us    (r_meas),
    .o_done  (w_div_done),
    .o_cm    (w_div_cm)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_pre     <= '0;
      r_us      <= '0;
      r_meas    <= '0;
      o_trig    <= '0;
      o_dis     <= '0;
      o_ch      <= '0;
      o_dis_vld <= 1'b0;
      o_timeout <= 1'b0;
`ifdef DIST_CM_EN
      r_div_start <= 1'b0;
`endif
    end else begin
      o_dis_vld <= 1'b0;
`ifdef DIST_CM_EN
      r_div_start <= 1'b0;
`endif
      // Later assignments in the case below restart the prescaler on state change.
      if (w_us_tick) begin
        r_pre <= '0;
        r_us  <= r_us + 16'd1;
      end else begin
        r_pre <= r_pre + 16'd1;
      end

      unique case (r_state)
        StIdle: begin
          if (i_en) begin
            r_state <= StTrig;
            o_trig  <= ONE << r_ptr;
            r_pre   <= '0;
            r_us    <= '0;
          end
        end

        StTrig: begin
          if (w_us_tick && (r_us == TRIG_LAST)) begin
            r_state <= StWaitRise;
            o_trig  <= '0;
            r_pre   <= '0;
            r_us    <= '0;
          end
        end

        StWaitRise: begin
          if (w_rise) begin
            r_state <= StMeasure;
            r_meas  <= '0;
            // The edge-detect cycle already saw echo high, so count it.
            r_pre   <= PRE_MEAS;
            r_us    <= '0;
          end else if (w_us_tick && (r_us == RISE_LAST)) begin
            r_state   <= StGuard;
            o_dis     <= TIMEOUT_VAL;
            o_ch      <= r_ptr;
            o_timeout <= 1'b1;
            o_dis_vld <= 1'b1;
            r_pre     <= '0;
            r_us      <= '0;
          end
        end

        StMeasure: begin
          if (w_fall) begin
`ifdef DIST_CM_EN
            r_state     <= StDiv;
            r_div_start <= 1'b1;
`else
            r_state   <= StResult;
            o_dis     <= r_meas;
            o_ch      <= r_ptr;
            o_timeout <= 1'b0;
            o_dis_vld <= 1'b1;
`endif
            r_pre <= '0;
            r_us  <= '0;
          end else if (w_us_tick && w_echo_cur) begin
            if (r_meas == ECHO_LAST) begin
              r_state   <= StGuard;
              o_dis     <= TIMEOUT_VAL;
              o_ch      <= r_ptr;
              o_timeout <= 1'b1;
              o_dis_vld <= 1'b1;
              r_pre     <= '0;
              r_us      <= '0;
            end else begin
              r_meas <= r_meas + 16'd1;
            end
          end
        end

`ifdef DIST_CM_EN
        StDiv: begin
          if (w_div_done) begin
            r_state   <= StResult;
            o_dis     <= w_div_cm;
            o_ch      <= r_ptr;
            o_timeout <= 1'b0;
            o_dis_vld <= 1'b1;
            r_pre     <= '0;
            r_us      <= '0;
          end
        end
`endif

        StResult: begin
          r_state <= StGuard;
          r_pre   <= '0;
          r_us    <= '0;
        end

        StGuard: begin
          if (w_us_tick && (r_us == GUARD_LAST)) begin
            r_ptr <= w_ptr_next;
            r_pre <= '0;
            r_us  <= '0;
            if (i_en) begin
              r_state <= StTrig;
              o_trig  <= ONE << w_ptr_next;
            end else begin
              r_state <= StIdle;
            end
          end
        end

        default: begin
          r_state <= StIdle;
          o_trig  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_scan_sched.sv
// Scoreboard bench for sr04_scan_sched: behavioural sensors push expected results on trigger fall.
module tb_sr04_scan_sched;

  localparam int unsigned PRE        = 4;
  localparam int unsigned ECHO_TO_US = 3000;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] dis;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  stuck_mask = 4'b0000;
  logic        pulse [4] = '{default: 1'b0};
  logic [3:0]  echo;
  logic [3:0]  trig;
  logic [15:0] dis;
  logic [1:0]  ch;
  logic        dis_vld;
  logic        timeout;
  logic        busy;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_strobe = 0;
  longint      cyc = 0;
  exp_t        sb_q[$];

  int unsigned cfg_rise [4];
  int unsigned cfg_high [4];
  int          cfg_mode [4];  // 0 normal pulse, 1 never rises, 2 stuck high

  assign echo = {pulse[3], pulse[2], pulse[1], pulse[0]} | stuck_mask;

  sr04_scan_sched #(
    .CLK_HZ     (4_000_000),
    .N_SENS     (4),
    .TRIG_US    (10),
    .RISE_TO_US (500),
    .ECHO_TO_US (ECHO_TO_US),
    .GUARD_US   (2000)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_echo    (echo),
    .o_trig    (trig),
    .o_dis     (dis),
    .o_ch      (ch),
    .o_dis_vld (dis_vld),
    .o_timeout (timeout),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_dis(input int unsigned us);
`ifdef DIST_CM_EN
    return 16'(us / 58);
`else
    return 16'(us);
`endif
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sens
    initial begin
      forever begin
        @(negedge trig[g]);
        if (rst_n) begin
          exp_t e;
          e.ch = 2'(g);
          if (cfg_mode[g] == 0 && cfg_high[g] < ECHO_TO_US) begin
            e.dis = exp_dis(cfg_high[g]);
            e.to  = 1'b0;
          end else begin
            e.dis = 16'hFFFF;
            e.to  = 1'b1;
          end
          sb_q.push_back(e);
          if (cfg_mode[g] == 0) begin
            repeat (cfg_rise[g] * PRE) @(negedge clk);
            pulse[g] = 1'b1;
            repeat (cfg_high[g] * PRE) @(negedge clk);
            pulse[g] = 1'b0;
          end
        end
      end
    end
  end

  logic   prev_vld = 1'b0;
  logic [3:0] prev_trig = 4'b0;
  logic   have_fall = 1'b0;
  longint last_fall = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_assert++;
      if (!$onehot0(trig)) begin
        n_fail++;
        $display("FAIL trig_onehot: trig=%b, required one-hot or zero", trig);
      end
      if (dis_vld) begin
        exp_t e;
        n_strobe++;
        n_assert++;
        if (prev_vld) begin
          n_fail++;
          $display("FAIL single_strobe: dis_vld high two cycles in a row");
        end
        n_assert++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: ch=%0d dis=%0d to=%b, none required", ch, dis, timeout);
        end else begin
          e = sb_q.pop_front();
          if ({ch, dis, timeout} !== {e.ch, e.dis, e.to}) begin
            n_fail++;
            $display("FAIL result: got ch=%0d dis=%0d to=%b, required ch=%0d dis=%0d to=%b",
                     ch, dis, timeout, e.ch, e.dis, e.to);
          end
        end
      end
      if (prev_trig != 4'b0 && trig == 4'b0) begin
        last_fall = cyc;
        have_fall = 1'b1;
      end
      if (prev_trig == 4'b0 && trig != 4'b0 && have_fall) begin
        n_assert++;
        if (cyc - last_fall < 8000) begin
          n_fail++;
          $display("FAIL trig_gap: got %0d clocks, required >= 8000", cyc - last_fall);
        end
      end
      prev_vld  = dis_vld;
      prev_trig = trig;
    end else begin
      have_fall = 1'b0;
      prev_vld  = 1'b0;
      prev_trig = 4'b0;
    end
  end

  task automatic wait_strobes(input int target, input int budget);
    while (n_strobe < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_assert++;
    if (n_strobe < target) begin
      n_fail++;
      $display("FAIL strobe_wait: got %0d strobes, required %0d", n_strobe, target);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_assert++; if (trig !== 4'b0)     begin n_fail++; $display("FAIL rst_trig: got %b, required 0", trig); end
    n_assert++; if (dis !== 16'd0)     begin n_fail++; $display("FAIL rst_dis: got %0d, required 0", dis); end
    n_assert++; if (ch !== 2'd0)       begin n_fail++; $display("FAIL rst_ch: got %0d, required 0", ch); end
    n_assert++; if (dis_vld !== 1'b0)  begin n_fail++; $display("FAIL rst_vld: got %b, required 0", dis_vld); end
    n_assert++; if (timeout !== 1'b0)  begin n_fail++; $display("FAIL rst_to: got %b, required 0", timeout); end
    n_assert++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: busy=%b, required 0", busy); end
  endtask

  task automatic test_first_channel;
    int n;
    int budget;
    en = 1'b1;
    budget = 20;
    while (!trig[0] && budget > 0) begin @(negedge clk); budget--; end
    n = 0;
    while (trig[0] && n < 1000) begin n++; @(negedge clk); end
    n_assert++;
    if (n != 40) begin n_fail++; $display("FAIL trig_width: got %0d clocks, required 40", n); end
    wait_strobes(1, 20000);
  endtask

  task automatic test_no_echo;
    int n;
    int budget;
    budget = 12000;
    while (!trig[1] && budget > 0) begin @(negedge clk); budget--; end
    budget = 100;
    while (trig[1] && budget > 0) begin @(negedge clk); budget--; end
    n = 0;
    while (!dis_vld && n < 3000) begin @(negedge clk); n++; end
    n_assert++;
    if (n != 2000) begin n_fail++; $display("FAIL rise_timeout: got %0d clocks, required 2000", n); end
    n = 0;
    while (!trig[2] && n < 9000) begin @(negedge clk); n++; end
    n_assert++;
    if (n != 8000) begin n_fail++; $display("FAIL guard_len: got %0d clocks, required 8000", n); end
  endtask

  task automatic test_stuck_echo;
    int budget;
    wait_strobes(3, 3000);
    stuck_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cfg_mode[i] = 0;
      cfg_rise[i] = 20;
      cfg_high[i] = 200;
    end
    budget = 9000;
    while (trig == 4'b0 && budget > 0) begin @(negedge clk); budget--; end
    n_assert++;
    if (trig !== 4'b1000) begin n_fail++; $display("FAIL stuck_advance: trig=%b, required 1000", trig); end
  endtask

  task automatic test_all_channels;
    wait_strobes(5, 25000);
  endtask

  task automatic test_en_drop;
    int  budget;
    logic seen;
    budget = 12000;
    while (!pulse[1] && budget > 0) begin @(negedge clk); budget--; end
    repeat (50) @(negedge clk);
    en = 1'b0;
    wait_strobes(6, 4000);
    seen = 1'b0;
    budget = 9000;
    while (busy && budget > 0) begin seen |= (trig != 4'b0); @(negedge clk); budget--; end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: busy=%b, required 0", busy); end
    repeat (100) begin seen |= (trig != 4'b0); @(negedge clk); end
    n_assert++;
    if (seen) begin n_fail++; $display("FAIL no_trig_when_off: trig seen=1, required 0"); end
    en = 1'b1;
    budget = 10;
    while (trig == 4'b0 && budget > 0) begin @(negedge clk); budget--; end
    n_assert++;
    if (trig !== 4'b0100) begin n_fail++; $display("FAIL resume_ch: trig=%b, required 0100", trig); end
  endtask

  task automatic test_reset_mid;
    int budget;
    budget = 1000;
    while (!pulse[2] && budget > 0) begin @(negedge clk); budget--; end
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({trig, dis, ch, dis_vld, timeout, busy} !== 25'd0) begin
      n_fail++;
      $display("FAIL async_rst: trig=%b dis=%0d ch=%0d vld=%b to=%b busy=%b, required all 0",
               trig, dis, ch, dis_vld, timeout, busy);
    end
    sb_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    budget = 20;
    while (trig == 4'b0 && budget > 0) begin @(negedge clk); budget--; end
    n_assert++;
    if (trig !== 4'b0001) begin n_fail++; $display("FAIL restart_ch0: trig=%b, required 0001", trig); end
  endtask

  initial begin
    cfg_mode[0] = 0; cfg_rise[0] = 100; cfg_high[0] = 580;
    cfg_mode[1] = 1; cfg_rise[1] = 0;   cfg_high[1] = 0;
    cfg_mode[2] = 2; cfg_rise[2] = 0;   cfg_high[2] = 0;
    cfg_mode[3] = 0; cfg_rise[3] = 50;  cfg_high[3] = 200;
    stuck_mask = 4'b0100;
    test_reset();
    test_first_channel();
    test_no_echo();
    test_stuck_echo();
    test_all_channels();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
